// File: rtl/sysid_check.sv
// Boot-time system-ID checker: Avalon-MM master that reads the ID word and the
// build timestamp from a system-ID slave and reports pass/fail with an error code.
module sysid_check #(
    parameter logic [31:0] EXPECTED_ID   = 32'h0000_0000,
    parameter logic [31:0] MIN_TIMESTAMP = 32'h0000_0000,
    parameter int          READ_LATENCY  = 0,
    parameter int          TIMEOUT       = 255,
    parameter int          MAX_RETRIES   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [31:0] id_out,
    output logic [31:0] timestamp_out
);

    typedef enum logic [2:0] {
        IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, FINISH
    } state_t;

    localparam logic [1:0]  LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
    localparam logic [15:0] TMO_MAX  = 16'(TIMEOUT);
    localparam logic [3:0]  RTY_MAX  = 4'(MAX_RETRIES);
    localparam bit          NO_LAT   = (READ_LATENCY == 0);

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_ID  = 2'b01;
    localparam logic [1:0] ERR_TS  = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_lat_cnt;
    logic [15:0] r_tmo_cnt;
    logic [3:0]  r_retry;
    logic        r_pass;
    logic [1:0]  r_err;
    logic [31:0] r_id;
    logic [31:0] r_ts;

    logic        w_rd_phase;
    logic        w_lat_phase;
    logic        w_tmo_hit;
    logic        w_accept;
    logic        w_retry_ok;
    logic        w_lat_done;
    logic        w_start;
    logic        w_cap_id;
    logic        w_cap_ts;
    logic [1:0]  w_chk_code;

    // The cycle the timeout counter sits at TIMEOUT is the one-cycle read drop;
    // waitrequest is ignored then so a late acceptance cannot race the retry.
    assign w_rd_phase  = (r_state == RD_ID) || (r_state == RD_TS);
    assign w_lat_phase = (r_state == LAT_ID) || (r_state == LAT_TS);
    assign w_tmo_hit   = w_rd_phase && (r_tmo_cnt == TMO_MAX);
    assign w_accept    = w_rd_phase && !w_tmo_hit && !avm_waitrequest;
    assign w_retry_ok  = (r_retry < RTY_MAX);
    assign w_lat_done  = (r_lat_cnt == LAT_LAST);
    assign w_start     = (r_state == IDLE) && start;
    assign w_cap_id    = ((r_state == RD_ID) && w_accept && NO_LAT) ||
                         ((r_state == LAT_ID) && w_lat_done);
    assign w_cap_ts    = ((r_state == RD_TS) && w_accept && NO_LAT) ||
                         ((r_state == LAT_TS) && w_lat_done);

    always_comb begin
        w_chk_code = ERR_OK;
        if (r_id != EXPECTED_ID)
            w_chk_code = ERR_ID;
        else if (r_ts < MIN_TIMESTAMP)
            w_chk_code = ERR_TS;
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = (r_state != IDLE);
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start)
                    w_next = RD_ID;
            end
            RD_ID: begin
                avm_read = !w_tmo_hit;
                if (w_tmo_hit)
                    w_next = w_retry_ok ? RD_ID : FINISH;
                else if (w_accept)
                    w_next = NO_LAT ? RD_TS : LAT_ID;
            end
            LAT_ID: begin
                if (w_lat_done)
                    w_next = RD_TS;
            end
            RD_TS: begin
                avm_read    = !w_tmo_hit;
                avm_address = 1'b1;
                if (w_tmo_hit)
                    w_next = w_retry_ok ? RD_ID : FINISH;
                else if (w_accept)
                    w_next = NO_LAT ? CHECK : LAT_TS;
            end
            LAT_TS: begin
                avm_address = 1'b1;
                if (w_lat_done)
                    w_next = CHECK;
            end
            CHECK: begin
                w_next = FINISH;
            end
            FINISH: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lat_cnt <= 2'd0;
            r_tmo_cnt <= 16'd0;
            r_retry   <= 4'd0;
            r_pass    <= 1'b0;
            r_err     <= ERR_OK;
            r_id      <= 32'd0;
            r_ts      <= 32'd0;
        end else begin
            if (w_lat_phase && !w_lat_done)
                r_lat_cnt <= r_lat_cnt + 2'd1;
            else
                r_lat_cnt <= 2'd0;

            if (w_start) begin
                r_tmo_cnt <= 16'd0;
                r_retry   <= 4'd0;
                r_pass    <= 1'b0;
                r_err     <= ERR_OK;
                r_id      <= 32'd0;
                r_ts      <= 32'd0;
            end else begin
                if (!w_rd_phase || w_tmo_hit || w_accept)
                    r_tmo_cnt <= 16'd0;
                else
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;

                // Retries restart the whole sequence; out of retries, report timeout.
                if (w_tmo_hit) begin
                    if (w_retry_ok) begin
                        r_retry <= r_retry + 4'd1;
                    end else begin
                        r_err  <= ERR_TMO;
                        r_pass <= 1'b0;
                    end
                end

                if (w_cap_id)
                    r_id <= avm_readdata;
                if (w_cap_ts)
                    r_ts <= avm_readdata;

                if (r_state == CHECK) begin
                    r_err  <= w_chk_code;
                    r_pass <= (w_chk_code == ERR_OK);
                end
            end
        end
    end

    assign pass          = r_pass;
    assign err_code      = r_err;
    assign id_out        = r_id;
    assign timestamp_out = r_ts;

endmodule

// File: doc/sysid_check.md
# sysid_check

Boot-time system identification checker: an Avalon-MM master that drives the system-ID slave's control port. On `start` it reads the ID word (address 0) and the timestamp word (address 1), compares them against build-time expectations, and reports pass/fail with an error code. Downstream boot logic (CPU hold-off, status LEDs) gates on `done`/`pass` so a mismatched FPGA image is caught before software runs.

## Interface
- `EXPECTED_ID`, 32'h0000_0000, required value of the word at address 0
- `MIN_TIMESTAMP`, 32'h0000_0000, timestamp at address 1 must be >= this value (unsigned)
- `READ_LATENCY`, 0, cycles from read acceptance to valid `avm_readdata`; legal range 0..3
- `TIMEOUT`, 255, max consecutive `avm_waitrequest` cycles per read; legal range 1..65535
- `MAX_RETRIES`, 3, full-sequence retries after a timeout; legal range 0..15

Ports:
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; begins a check when idle
- `avm_address`  out  1  0 = ID word, 1 = timestamp word
- `avm_read`  out  1  read request
- `avm_waitrequest`  in  1  slave stall
- `avm_readdata`  in  32  read data
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `pass`  out  1  result, held until next accepted `start`
- `err_code`  out  2  00 ok, 01 ID mismatch, 10 timestamp too old, 11 timeout; held like `pass`
- `id_out`  out  32  captured ID word
- `timestamp_out`  out  32  captured timestamp word

## Operation
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, FINISH.
- IDLE: `start` = 1 -> RD_ID; clear `pass`, `err_code`, `id_out`, `timestamp_out`, timeout counter and retry counter; set `busy`.
- RD_ID: `avm_read` = 1, `avm_address` = 0. Read is accepted on an edge where `avm_waitrequest` = 0. With READ_LATENCY = 0, `avm_readdata` is captured into `id_out` on that edge and the FSM moves to RD_TS; otherwise it moves to LAT_ID.
- LAT_ID: `avm_read` = 0; a counter runs READ_LATENCY cycles, then captures `id_out` and moves to RD_TS.
- RD_TS/LAT_TS: identical to the ID read, but with `avm_address` = 1, capturing into `timestamp_out`.
- CHECK: one cycle. Priority: `id_out` != EXPECTED_ID gives 01; else `timestamp_out` < MIN_TIMESTAMP gives 10; else 00. `pass` = (code == 00). The FSM then moves to FINISH.
- FINISH: `done` = 1 for this cycle and `busy` = 0 after it; the FSM returns to IDLE.
- Timeout: in RD_* the 16-bit counter increments each cycle `avm_waitrequest` = 1 and clears on acceptance. When it reaches TIMEOUT, `avm_read` drops for one cycle.
  - If retries < MAX_RETRIES: increment retries and restart at RD_ID.
  - Otherwise: `err_code` = 11, `pass` = 0, go to FINISH (CHECK is skipped).
- Mismatch codes (01, 10) are never retried.
- `start` while `busy` is ignored. `start` in the FINISH cycle is also ignored.
- `avm_address` is held stable while `avm_read` = 1 and `avm_waitrequest` = 1.

## Timing
- Reset values: `avm_read` 0, `avm_address` 0, `busy` 0, `done` 0, `pass` 0, `err_code` 00, `id_out` 0, `timestamp_out` 0; FSM in IDLE.
- Reset mid-sequence: all outputs take reset values after the reset edge. The in-flight read is abandoned, and no `done` is generated.
- Zero wait states, start sampled at edge k:
  - `avm_read` is high after edge k (address 0) and after edge k+1+L (address 1), where L = READ_LATENCY.
  - `done` is high after edge k+3+2L.
- Each waitrequest cycle adds one cycle to the total.
- Result outputs are valid in the same cycle `done` is high and remain stable until the next accepted `start`.

## Test plan
- READ_LATENCY = 0, zero waits, slave returns 0x0 / 0x6378_3DF5, EXPECTED_ID = 0, MIN_TIMESTAMP = 0x6000_0000 -> `done` 3 cycles after start; `pass` = 1, `err_code` = 00, `timestamp_out` = 0x6378_3DF5.
- Slave ID = 0x0000_0001 -> `err_code` = 01, `pass` = 0, no retry. Timestamp 0x5FFF_FFFF with correct ID -> `err_code` = 10.
- READ_LATENCY = 2, waitrequest high for 4 cycles on each read -> `done` at 3 + 4 + 8 = 15 cycles after start; correct data captured and address held during stalls.
- TIMEOUT = 8, MAX_RETRIES = 2, waitrequest stuck high -> exactly 3 read attempts on address 0, then `err_code` = 11 and a single `done` pulse.
- `reset` asserted during LAT_TS, then `start` pulsed again -> outputs at reset values, clean full sequence follows; `start` while busy produces no extra `done`.
